// File: rtl/captura_datos_param_pkg.sv
// Shared types and constants for the OV7670 capture front end: FSM states,
// output-format codes, RGB565 field positions and the colour-bar table.
package cam_pkg;

   typedef enum logic [1:0] {WAIT_VS, WAIT_FS, CAPTURE} cap_state_t;

   localparam int FMT_RGB332 = 0;
   localparam int FMT_RGB565 = 1;

   localparam int R_HI = 15;
   localparam int G_HI = 10;
   localparam int B_HI = 4;

   // white, yellow, cyan, green, magenta, red, blue, black
   localparam logic [0:7][15:0] BAR_TBL = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                           16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   function automatic logic [7:0] pack332(input logic [15:0] p);
      return {p[R_HI -: 3], p[G_HI -: 3], p[B_HI -: 2]};
   endfunction

endpackage

// File: rtl/captura_datos_param_if.sv
// Frame-buffer write bus: data word, linear address and a one-cycle strobe.
interface captura_datos_param_if #(
   parameter int DW = 8,
   parameter int AW = 15
);
   logic [DW-1:0] DATARAMIN;
   logic [AW-1:0] ADDRRAMIN;
   logic          regW;

   modport master (output DATARAMIN, output ADDRRAMIN, output regW);
   modport slave  (input  DATARAMIN, input  ADDRRAMIN, input  regW);
endinterface

// File: rtl/captura_datos_param_pixel_pack.sv
// Registered RGB565 -> RAM word formatter; one cycle from ld to dout.
module pixel_pack import cam_pkg::*; #(
   parameter int OUT_FMT = FMT_RGB332,
   parameter int DW      = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ld,
   input  logic [15:0]   pix,
   output logic [DW-1:0] dout
);

   logic [DW-1:0] fmt;

   generate
      if (OUT_FMT == FMT_RGB565) begin : g_565
         assign fmt = DW'(pix);
      end else begin : g_332
         assign fmt = DW'(pack332(pix));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst)     dout <= '0;
      else if (ld) dout <= fmt;
   end

endmodule

// File: rtl/captura_datos_param.sv
// OV7670 capture: byte-pair assembly, DEC_X/DEC_Y decimation, linear RAM writes.
// Optional CAPT_TESTPAT_EN adds tp_sel, which swaps camera bytes for 8 colour bars.
module captura_datos_param import cam_pkg::*; #(
   parameter int SRC_W   = 160,
   parameter int SRC_H   = 120,
   parameter int DEC_X   = 1,
   parameter int DEC_Y   = 1,
   parameter int OUT_FMT = FMT_RGB332,
   parameter int DW      = 8,
   parameter int AW      = 15
) (
   input  logic       PCLK,
   input  logic       rst,
   input  logic       VSYNC,
   input  logic       HREF,
   input  logic [7:0] datos,
   input  logic       en,
`ifdef CAPT_TESTPAT_EN
   input  logic       tp_sel,
`endif
   captura_datos_param_if.master ram,
   output logic       frame_done,
   output logic       busy,
   output logic       line_err
);

   localparam int MAXA = (SRC_W / DEC_X) * (SRC_H / DEC_Y) - 1;
   localparam int XW   = $clog2(SRC_W + 1) + 1;
   localparam int YW   = $clog2(SRC_H + 1) + 1;

   cap_state_t    st, st_nx;
   logic          vs_q, hr_q;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          ph;
   logic [7:0]    hi_byte;
   logic [7:0]    byte_in;
   logic          full;
   logic          vs_fall, hr_fall, take, keep, pix_ld;

`ifdef CAPT_TESTPAT_EN
   logic [2:0]  bar_idx;
   logic [15:0] bar;
   assign bar_idx = 3'((int'(x) * 8) / SRC_W);
   assign bar     = BAR_TBL[bar_idx];
   assign byte_in = tp_sel ? (ph ? bar[7:0] : bar[15:8]) : datos;
`else
   assign byte_in = datos;
`endif

   assign vs_fall = vs_q & ~VSYNC;
   assign hr_fall = hr_q & ~HREF;
   // VSYNC has priority: a byte arriving with the VSYNC rise is dropped
   assign take    = (st == CAPTURE) && !VSYNC && HREF;
   assign keep    = (int'(x) % DEC_X == 0) && (int'(y) % DEC_Y == 0) &&
                    (int'(x) < SRC_W) && (int'(y) < SRC_H);
   assign pix_ld  = take && ph && keep && !full;
   assign busy    = (st == CAPTURE);

   always_comb begin
      st_nx = st;
      case (st)
         WAIT_VS: if (VSYNC)   st_nx = WAIT_FS;
         WAIT_FS: if (vs_fall) st_nx = en ? CAPTURE : WAIT_VS;
         CAPTURE: if (VSYNC)   st_nx = WAIT_FS;
         default:              st_nx = WAIT_VS;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (rst) begin
         st            <= WAIT_VS;
         vs_q          <= 1'b0;
         hr_q          <= 1'b0;
         x             <= '0;
         y             <= '0;
         ph            <= 1'b0;
         hi_byte       <= '0;
         full          <= 1'b0;
         line_err      <= 1'b0;
         frame_done    <= 1'b0;
         ram.regW      <= 1'b0;
         ram.ADDRRAMIN <= '0;
      end else begin
         st         <= st_nx;
         vs_q       <= VSYNC;
         hr_q       <= HREF;
         ram.regW   <= pix_ld;
         frame_done <= (st == CAPTURE) && VSYNC;

         // address advances after each write and parks at the last slot
         if (ram.regW) begin
            if (ram.ADDRRAMIN == AW'(MAXA)) full <= 1'b1;
            else                            ram.ADDRRAMIN <= ram.ADDRRAMIN + AW'(1);
         end

         case (st)
            WAIT_FS: begin
               x             <= '0;
               y             <= '0;
               ph            <= 1'b0;
               full          <= 1'b0;
               ram.ADDRRAMIN <= '0;
               if (vs_fall) line_err <= 1'b0;
            end
            CAPTURE: begin
               if (take) begin
                  ph <= ~ph;
                  if (!ph)      hi_byte <= byte_in;
                  else if (~&x) x <= x + XW'(1);
               end else if (!VSYNC && hr_fall) begin
                  x  <= '0;
                  ph <= 1'b0;
                  if (~&y) y <= y + YW'(1);
                  if (ph || int'(x) != SRC_W) line_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   pixel_pack #(.OUT_FMT(OUT_FMT), .DW(DW)) u_pack (
      .clk  (PCLK),
      .rst  (rst),
      .ld   (pix_ld),
      .pix  ({hi_byte, byte_in}),
      .dout (ram.DATARAMIN)
   );

endmodule

// File: tb/tb_captura_datos_param.sv
// Bench: full QQVGA frame on default and 2x2-decimated instances, plus a small
// 8x4 instance for red data, line errors, reset mid-frame and enable gating.
module tb_captura_datos_param;

   logic       PCLK = 1'b0;
   logic       rst, rst_s, grp, vs, hr, en_s, cap;
   logic [7:0] dat;
   logic       vs_l, hr_l, vs_s, hr_s, rst_c;
   int         exp_addr, nchk, nerr;
   int         cnt_a, cnt_b, cnt_c, cnt_d, fd_a, fd_c;

   always #5 PCLK = ~PCLK;

   assign vs_l  = !grp & vs;
   assign hr_l  = !grp & hr;
   assign vs_s  = grp & vs;
   assign hr_s  = grp & hr;
   assign rst_c = rst | rst_s;

   logic fd_ao, bz_a, le_a, fd_bo, bz_b, le_b, fd_co, bz_c, le_c;

   captura_datos_param_if #(.DW(8),  .AW(15)) ra ();
   captura_datos_param_if #(.DW(16), .AW(13)) rb ();
   captura_datos_param_if #(.DW(8),  .AW(5))  rc ();

   captura_datos_param #(.SRC_W(160), .SRC_H(120), .DEC_X(1), .DEC_Y(1),
                         .OUT_FMT(0), .DW(8), .AW(15)) u_a (
      .PCLK(PCLK), .rst(rst), .VSYNC(vs_l), .HREF(hr_l), .datos(dat), .en(1'b1),
`ifdef CAPT_TESTPAT_EN
      .tp_sel(1'b0),
`endif
      .ram(ra), .frame_done(fd_ao), .busy(bz_a), .line_err(le_a));

   captura_datos_param #(.SRC_W(160), .SRC_H(120), .DEC_X(2), .DEC_Y(2),
                         .OUT_FMT(1), .DW(16), .AW(13)) u_b (
      .PCLK(PCLK), .rst(rst), .VSYNC(vs_l), .HREF(hr_l), .datos(dat), .en(1'b1),
`ifdef CAPT_TESTPAT_EN
      .tp_sel(1'b0),
`endif
      .ram(rb), .frame_done(fd_bo), .busy(bz_b), .line_err(le_b));

   captura_datos_param #(.SRC_W(8), .SRC_H(4), .DEC_X(1), .DEC_Y(1),
                         .OUT_FMT(0), .DW(8), .AW(5)) u_c (
      .PCLK(PCLK), .rst(rst_c), .VSYNC(vs_s), .HREF(hr_s), .datos(dat), .en(en_s),
`ifdef CAPT_TESTPAT_EN
      .tp_sel(1'b0),
`endif
      .ram(rc), .frame_done(fd_co), .busy(bz_c), .line_err(le_c));

`ifdef CAPT_TESTPAT_EN
   logic fd_do, bz_d, le_d;
   logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};
   captura_datos_param_if #(.DW(16), .AW(15)) rd ();
   captura_datos_param #(.SRC_W(160), .SRC_H(120), .DEC_X(1), .DEC_Y(1),
                         .OUT_FMT(1), .DW(16), .AW(15)) u_d (
      .PCLK(PCLK), .rst(rst), .VSYNC(vs_l), .HREF(hr_l), .datos(dat), .en(1'b1),
      .tp_sel(1'b1),
      .ram(rd), .frame_done(fd_do), .busy(bz_d), .line_err(le_d));
`endif

   typedef struct packed {logic [4:0] a; logic [7:0] d;} exp_t;
   exp_t q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         if (nerr <= 20) $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] pixv(input int x, input int y);
      return {1'b1, y[6:0], x[7:0]};
   endfunction

   function automatic logic [7:0] p332(input logic [15:0] p);
      return {p[15:13], p[10:8], p[4:3]};
   endfunction

   task automatic cyc();
      @(posedge PCLK);
      #1;
   endtask

   task automatic vs_pulse(input bit capn);
      hr = 1'b0;
      vs = 1'b1;
      repeat (3) cyc();
      vs       = 1'b0;
      cap      = capn;
      exp_addr = 0;
      repeat (4) cyc();
   endtask

   task automatic send_line(input int y, input int nb, input bit red);
      logic [15:0] p;
      exp_t        e;
      for (int b = 0; b < nb; b++) begin
         p   = red ? 16'hF800 : pixv(b / 2, y);
         hr  = 1'b1;
         dat = (b % 2 == 1) ? p[7:0] : p[15:8];
         if (grp && cap && (b % 2 == 1) && (b / 2 < 8) && (y < 4)) begin
            e.a = 5'(exp_addr);
            e.d = red ? 8'hE0 : p332(p);
            q.push_back(e);
            exp_addr++;
         end
         cyc();
      end
      hr  = 1'b0;
      dat = 8'h00;
      repeat (4) cyc();
   endtask

   task automatic frame(input int nl, input int npx, input bit red);
      for (int y = 0; y < nl; y++) send_line(y, 2 * npx, red);
   endtask

   always @(negedge PCLK) begin
      if (ra.regW === 1'b1) begin
         chk("A addr", 32'(ra.ADDRRAMIN), 32'(cnt_a));
         chk("A data", 32'(ra.DATARAMIN), 32'(p332(pixv(cnt_a % 160, cnt_a / 160))));
         cnt_a++;
      end
      if (rb.regW === 1'b1) begin
         chk("B addr", 32'(rb.ADDRRAMIN), 32'(cnt_b));
         chk("B data", 32'(rb.DATARAMIN), 32'(pixv(2 * (cnt_b % 80), 2 * (cnt_b / 80))));
         cnt_b++;
      end
`ifdef CAPT_TESTPAT_EN
      if (rd.regW === 1'b1) begin
         chk("D addr", 32'(rd.ADDRRAMIN), 32'(cnt_d));
         chk("D data", 32'(rd.DATARAMIN), 32'(bars[(cnt_d % 160) / 20]));
         cnt_d++;
      end
`endif
      if (rc.regW === 1'b1) begin
         if (q.size() == 0) chk("C extra wr addr", 32'(rc.ADDRRAMIN), 32'hFFFF_FFFF);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("C addr", 32'(rc.ADDRRAMIN), 32'(e.a));
            chk("C data", 32'(rc.DATARAMIN), 32'(e.d));
            cnt_c++;
         end
      end
      if (fd_ao === 1'b1) fd_a++;
      if (fd_co === 1'b1) fd_c++;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: run exceeded time budget");
      $fatal(1);
   end

   initial begin
      nchk = 0; nerr = 0; cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0; fd_a = 0; fd_c = 0;
      rst = 1'b1; rst_s = 1'b0; grp = 1'b0; vs = 1'b0; hr = 1'b0; dat = 8'h00;
      en_s = 1'b1; cap = 1'b0; exp_addr = 0;
      repeat (3) cyc();
      chk("rst A regW", 32'(ra.regW), 0);
      chk("rst A addr", 32'(ra.ADDRRAMIN), 0);
      chk("rst A data", 32'(ra.DATARAMIN), 0);
      chk("rst A busy", 32'(bz_a), 0);
      chk("rst C fdone", 32'(fd_co), 0);
      chk("rst C lerr", 32'(le_c), 0);
      rst = 1'b0;
      cyc();

      // full QQVGA frame on the large instances
      vs_pulse(1'b1);
      chk("A busy", 32'(bz_a), 1);
      frame(120, 160, 1'b0);
      vs_pulse(1'b1);
      repeat (3) cyc();
      chk("A writes", 32'(cnt_a), 19200);
      chk("B writes", 32'(cnt_b), 4800);
      chk("A frame_done", 32'(fd_a), 1);
      chk("A line_err", 32'(le_a), 0);
`ifdef CAPT_TESTPAT_EN
      chk("D writes", 32'(cnt_d), 19200);
`endif

      // small instance: red frame
      grp = 1'b1;
      vs_pulse(1'b1);
      chk("C busy", 32'(bz_c), 1);
      frame(4, 8, 1'b1);
      vs_pulse(1'b1);
      chk("C red writes", 32'(cnt_c), 32);
      chk("C fdone 1", 32'(fd_c), 1);
      chk("C lerr red", 32'(le_c), 0);

      // long line 0 and an extra line: extras dropped, line_err on length
      send_line(0, 18, 1'b0);
      for (int y = 1; y < 5; y++) send_line(y, 16, 1'b0);
      chk("C lerr long", 32'(le_c), 1);
      chk("C bound writes", 32'(cnt_c), 64);
      vs_pulse(1'b1);
      chk("C lerr clr", 32'(le_c), 0);
      chk("C fdone 2", 32'(fd_c), 2);

      // odd byte count on line 1
      send_line(0, 16, 1'b0);
      send_line(1, 15, 1'b0);
      chk("C lerr odd", 32'(le_c), 1);
      send_line(2, 16, 1'b0);
      send_line(3, 16, 1'b0);
      chk("C lerr sticky", 32'(le_c), 1);
      vs_pulse(1'b1);
      chk("C odd writes", 32'(cnt_c), 95);
      chk("C lerr clr2", 32'(le_c), 0);

      // reset mid-frame
      send_line(0, 16, 1'b0);
      send_line(1, 16, 1'b0);
      rst_s = 1'b1;
      cap   = 1'b0;
      repeat (2) cyc();
      rst_s = 1'b0;
      chk("C rst addr", 32'(rc.ADDRRAMIN), 0);
      chk("C rst data", 32'(rc.DATARAMIN), 0);
      chk("C rst busy", 32'(bz_c), 0);
      send_line(2, 16, 1'b0);
      send_line(3, 16, 1'b0);
      vs_pulse(1'b1);
      chk("C fdone post rst", 32'(fd_c), 3);
      frame(4, 8, 1'b0);
      vs_pulse(1'b1);
      frame(4, 8, 1'b0);
      en_s = 1'b0;
      vs_pulse(1'b0);
      chk("C rst writes", 32'(cnt_c), 175);
      chk("C fdone 5", 32'(fd_c), 5);
      chk("C idle busy", 32'(bz_c), 0);

      // en low at frame start, high mid-frame; then dropped mid-frame
      send_line(0, 16, 1'b0);
      en_s = 1'b1;
      for (int y = 1; y < 4; y++) send_line(y, 16, 1'b0);
      chk("C en0 writes", 32'(cnt_c), 175);
      vs_pulse(1'b1);
      send_line(0, 16, 1'b0);
      send_line(1, 16, 1'b0);
      en_s = 1'b0;
      send_line(2, 16, 1'b0);
      send_line(3, 16, 1'b0);
      vs_pulse(1'b0);
      repeat (3) cyc();
      chk("C en writes", 32'(cnt_c), 207);
      chk("C fdone 6", 32'(fd_c), 6);
      chk("C end busy", 32'(bz_c), 0);
      chk("C queue empty", 32'(q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
